face_display_ctrl: RTL and testbench
====================================

Name: face_display_ctrl

Overview:
- Parametrised multi-event face display controller for the game's 7-segment face digits.
- Accepts NUM_EVENTS one-cycle event pulses (new high score, died, level up, ...) and queues them one-deep per channel.
- Shows each event's eyes/mouth pattern for a runtime-programmable number of timebase ticks, with a blank gap between consecutive faces.
- Sits between game logic and the display mux; replaces the fixed happy/sad, one-second face block.

Parameters:
- NUM_EVENTS, 4: number of event channels. Index 0 is highest priority.
- DUR_W, 16: width of the hold_ticks duration input.
- GAP_TICKS, 2: blank ticks inserted between consecutive faces. 0 means no gap.
- BLANK_PAT, 7'h7F: segment pattern driven when no face is shown (active-low segments, all off).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- event_pulse  in  NUM_EVENTS  one-cycle event requests, one bit per channel
- tick  in  1  one-cycle timebase strobe (1 ms from the system timebase)
- hold_ticks  in  DUR_W  face display duration in ticks; sampled on face start
- eyes_pat  in  7*NUM_EVENTS  eyes pattern per channel; channel i at [7i+6:7i]
- mouth_pat  in  7*NUM_EVENTS  mouth pattern per channel, same packing
- eyes  out  7  eyes segment drive (registered)
- mouth  out  7  mouth segment drive (registered)
- show_face  out  1  high while a face is displayed
- active_id  out  $clog2(NUM_EVENTS)  channel currently shown; 0 when idle
- pending  out  NUM_EVENTS  queued, not-yet-shown events

Behaviour:
- Reset is asynchronous. On reset, all outputs and internal state clear immediately, including mid-display:
  - state = IDLE, pending = 0, counter = 0, show_face = 0, active_id = 0
  - eyes = mouth = BLANK_PAT
- Pending register:
  - pending[i] sets on event_pulse[i].
  - pending[i] clears in the cycle channel i is selected for display.
  - A pulse on an already-pending channel is a no-op: queue depth is 1 per channel, with no counting.
- State machine:
  - IDLE:
    - If pending != 0, select the lowest set index.
    - Latch its eyes/mouth patterns and load counter = max(hold_ticks, 1).
    - Next state SHOW.
  - SHOW:
    - show_face = 1. eyes/mouth hold the latched patterns; pattern inputs changing mid-show have no effect.
    - Counter decrements on tick.
    - On tick with counter == 1, leave SHOW: go to GAP if GAP_TICKS > 0, else IDLE.
  - GAP:
    - show_face = 0, outputs at BLANK_PAT, counter loaded with GAP_TICKS on entry.
    - Decrements on tick; on tick with counter == 1, go to IDLE.
    - New pulses still queue during GAP.
- Latency:
  - Pulse in cycle 0 sets pending in cycle 1.
  - show_face, eyes and mouth are valid from cycle 2, provided the block was IDLE.
- Retrigger:
  - event_pulse[active_id] during SHOW reloads the counter with max(hold_ticks, 1).
  - It does not set pending.
  - A retrigger and a tick in the same cycle: the reload wins.
- Non-preemptive by default. A higher-priority pulse during SHOW only queues.
- Simultaneous pulses on several channels: all are queued and served in priority order.
- Duration: hold_ticks == 0 behaves as 1. Counter width is DUR_W. GAP_TICKS must fit in DUR_W.

Optional Feature:
- Macro: FACE_PREEMPT_EN.
- When defined:
  - In SHOW, if any pending channel has index < active_id, the current face is dropped without a gap.
  - The next cycle selects that channel, latches its patterns and reloads the counter. show_face stays 1 throughout.
  - The dropped channel is not re-queued.
- When undefined: strict non-preemptive behaviour as above, with no preemption logic synthesised.

Decomposition:
- Package face_pkg:
  - state enum (IDLE, SHOW, GAP)
  - BLANK_PAT default constant
  - helper for index width from NUM_EVENTS
- Sub-module face_hold_timer:
  - loadable DUR_W down-counter
  - ports: load, load_val, tick, expire (tick && count == 1)
  - used for both the SHOW and GAP phases

Test Plan:
1. Reset, then event_pulse = 4'b0010, hold_ticks = 3, GAP_TICKS = 2:
   - show_face rises 2 cycles after the pulse, with channel 1 patterns and active_id = 1.
   - It falls on the 3rd tick, then outputs are blank for 2 ticks.
2. event_pulse = 4'b1001 in one cycle:
   - channel 0 shows first while pending = 4'b1000
   - after the gap, channel 3 shows and pending = 0.
3. Retrigger:
   - hold_ticks = 5; re-pulse channel 2 after 3 ticks of its display.
   - show_face stays high a further 5 ticks (8 total). A retrigger coinciding with a tick still yields 5.
4. hold_ticks = 0:
   - the face lasts exactly 1 tick.
   - pulsing an already-pending channel 3 times gives only one display.
5. Assert rst mid-SHOW, asynchronously between clock edges:
   - outputs go to 7'h7F, show_face = 0 and pending = 0 immediately, before the next clk edge.
6. With FACE_PREEMPT_EN defined: channel 2 showing, then channel 0 pulses.
   - the next cycle after pending sets shows channel 0 with show_face continuously high.
   - without the macro, channel 0 waits for channel 2's end plus the gap.

Source files
------------

// File: rtl/face_pkg.sv
// Shared types and constants for the face display controller.
package face_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShow,
    StGap
  } face_state_e;

  // Active-low segments: all off.
  localparam logic [6:0] BlankPatDefault = 7'h7F;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/face_hold_timer.sv
// Loadable down-counter in timebase ticks; shared by the show and gap phases.
module face_hold_timer #(
  parameter int unsigned DUR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  input  logic             tick,
  output logic             expire
);

  logic [DUR_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - DUR_W'(1);
    end
  end

  assign expire = tick && (count == DUR_W'(1));

endmodule

// File: rtl/face_display_ctrl.sv
// Multi-event 7-segment face display controller with one-deep per-channel queue.
// Optional macro FACE_PREEMPT_EN lets a higher-priority pending event replace the shown face.
module face_display_ctrl
  import face_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = 4,
  parameter int unsigned DUR_W      = 16,
  parameter int unsigned GAP_TICKS  = 2,
  parameter logic [6:0]  BLANK_PAT  = BlankPatDefault
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_EVENTS-1:0]             event_pulse,
  input  logic                              tick,
  input  logic [DUR_W-1:0]                  hold_ticks,
  input  logic [7*NUM_EVENTS-1:0]           eyes_pat,
  input  logic [7*NUM_EVENTS-1:0]           mouth_pat,
  output logic [6:0]                        eyes,
  output logic [6:0]                        mouth,
  output logic                              show_face,
  output logic [idx_w(NUM_EVENTS)-1:0]      active_id,
  output logic [NUM_EVENTS-1:0]             pending
);

  localparam int unsigned IdxW = idx_w(NUM_EVENTS);
  localparam logic [DUR_W-1:0] GapVal = DUR_W'(GAP_TICKS);

  face_state_e         state;
  logic                any_pending;
  logic [IdxW-1:0]     sel_idx;
  logic [6:0]          sel_eyes, sel_mouth;
  logic [DUR_W-1:0]    hold_eff;
  logic                retrig, preempt, start, expire;
  logic                t_load;
  logic [DUR_W-1:0]    t_val;
  logic [NUM_EVENTS-1:0] pending_d;

  // Lowest set index wins.
  always_comb begin
    any_pending = |pending;
    sel_idx     = '0;
    sel_eyes    = BLANK_PAT;
    sel_mouth   = BLANK_PAT;
    for (int i = int'(NUM_EVENTS) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx   = IdxW'(i);
        sel_eyes  = eyes_pat[7*i +: 7];
        sel_mouth = mouth_pat[7*i +: 7];
      end
    end
  end

  assign hold_eff = (hold_ticks == '0) ? DUR_W'(1) : hold_ticks;
  assign retrig   = (state == StShow) && event_pulse[active_id];

`ifdef FACE_PREEMPT_EN
  assign preempt = (state == StShow) && any_pending && (sel_idx < active_id);
`else
  assign preempt = 1'b0;
`endif

  assign start = ((state == StIdle) && any_pending) || preempt;

  // A pulse on a channel that is already queued is dropped, even in its selection cycle.
  always_comb begin
    pending_d = pending;
    for (int i = 0; i < int'(NUM_EVENTS); i++) begin
      if (pending[i]) begin
        pending_d[i] = !(start && (sel_idx == IdxW'(i)));
      end else begin
        pending_d[i] = event_pulse[i] && !(retrig && (active_id == IdxW'(i)));
      end
    end
  end

  // Retrigger reload takes priority over a coincident expiring tick.
  always_comb begin
    t_load = 1'b0;
    t_val  = hold_eff;
    if (start || retrig) begin
      t_load = 1'b1;
    end else if ((state == StShow) && expire) begin
      t_load = 1'b1;
      t_val  = GapVal;
    end
  end

  face_hold_timer #(
    .DUR_W (DUR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .tick     (tick),
    .expire   (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      pending   <= '0;
      eyes      <= BLANK_PAT;
      mouth     <= BLANK_PAT;
      show_face <= 1'b0;
      active_id <= '0;
    end else begin
      pending <= pending_d;
      if (start) begin
        state     <= StShow;
        eyes      <= sel_eyes;
        mouth     <= sel_mouth;
        show_face <= 1'b1;
        active_id <= sel_idx;
      end else begin
        case (state)
          StShow: begin
            if (!retrig && expire) begin
              state     <= (GAP_TICKS > 0) ? StGap : StIdle;
              eyes      <= BLANK_PAT;
              mouth     <= BLANK_PAT;
              show_face <= 1'b0;
              active_id <= '0;
            end
          end
          StGap: begin
            if (expire) state <= StIdle;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_face_display_ctrl.sv
// Directed bench for face_display_ctrl with a tick-level reference model and per-cycle compare.
module tb_face_display_ctrl;

  localparam int NE  = 4;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NE-1:0] event_pulse = '0;
  logic          tick = 1'b0;
  logic [15:0]   hold_ticks = 16'd3;
  logic [7*NE-1:0] eyes_pat, mouth_pat;
  logic [6:0]    eyes, mouth;
  logic          show_face;
  logic [1:0]    active_id;
  logic [NE-1:0] pending;

  int errors = 0;
  int checks = 0;

  face_display_ctrl #(
    .NUM_EVENTS (NE),
    .DUR_W      (16),
    .GAP_TICKS  (GAP),
    .BLANK_PAT  (7'h7F)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .event_pulse (event_pulse),
    .tick        (tick),
    .hold_ticks  (hold_ticks),
    .eyes_pat    (eyes_pat),
    .mouth_pat   (mouth_pat),
    .eyes        (eyes),
    .mouth       (mouth),
    .show_face   (show_face),
    .active_id   (active_id),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 showing, 2 blank gap; m_left counts ticks still to go.
  logic [NE-1:0] m_pend  = '0;
  int            m_phase = 0;
  int            m_left  = 0;
  int            m_id    = 0;
  logic [6:0]    m_eyes  = 7'h7F;
  logic [6:0]    m_mouth = 7'h7F;

  always @(posedge clk or posedge rst) begin : model
    int low, hold, ph, left, id;
    bit rt, take;
    logic [NE-1:0] np;
    logic [6:0] e, m;
    if (rst) begin
      m_pend <= '0; m_phase <= 0; m_left <= 0; m_id <= 0;
      m_eyes <= 7'h7F; m_mouth <= 7'h7F;
    end else begin
      hold = (hold_ticks == 0) ? 1 : int'(hold_ticks);
      ph = m_phase; left = m_left; id = m_id; e = m_eyes; m = m_mouth;
      low = -1;
      for (int i = NE - 1; i >= 0; i--) if (m_pend[i]) low = i;
      rt = (ph == 1) && event_pulse[id];
      np = m_pend;
      for (int i = 0; i < NE; i++)
        if (!m_pend[i] && event_pulse[i] && !(rt && i == id)) np[i] = 1'b1;
      take = (ph == 0) && (low >= 0);
`ifdef FACE_PREEMPT_EN
      if (ph == 1 && low >= 0 && low < id) take = 1'b1;
`endif
      if (take) begin
        np[low] = 1'b0;
        id = low; e = eyes_pat[7*low +: 7]; m = mouth_pat[7*low +: 7];
        left = hold; ph = 1;
      end else if (ph == 1) begin
        if (rt) left = hold;
        else if (tick) begin
          left = left - 1;
          if (left == 0) begin ph = (GAP > 0) ? 2 : 0; left = GAP; end
        end
      end else if (ph == 2 && tick) begin
        left = left - 1;
        if (left == 0) ph = 0;
      end
      m_pend <= np; m_phase <= ph; m_left <= left; m_id <= id;
      m_eyes <= e; m_mouth <= m;
    end
  end

  always @(posedge clk) begin : compare
    #2;
    if (!rst) begin
      chk("cyc_show",    show_face, m_phase == 1);
      chk("cyc_eyes",    eyes,      (m_phase == 1) ? m_eyes  : 7'h7F);
      chk("cyc_mouth",   mouth,     (m_phase == 1) ? m_mouth : 7'h7F);
      chk("cyc_active",  active_id, (m_phase == 1) ? m_id    : 0);
      chk("cyc_pending", pending,   m_pend);
    end
  end

  task automatic pulse(input logic [NE-1:0] mask);
    event_pulse = mask;
    @(negedge clk);
    event_pulse = '0;
  endtask

  task automatic tick1();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick1();
  endtask

  task automatic count_show(output int n);
    n = 0;
    while (show_face && n < 40) begin
      tick1();
      n++;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    for (int i = 0; i < NE; i++) begin
      eyes_pat[7*i +: 7]  = 7'(7'h11 * (i + 1));
      mouth_pat[7*i +: 7] = 7'(7'h05 + 7'h10 * i);
    end
    repeat (3) @(negedge clk);
    chk("rst_eyes", eyes, 7'h7F);
    chk("rst_show", show_face, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pending", pending, 0);
    chk("rst_active", active_id, 0);

    // 1: single event, latency, hold 3, gap 2
    hold_ticks = 16'd3;
    pulse(4'b0010);
    chk("t1_pend", pending, 4'b0010);
    chk("t1_noshow_yet", show_face, 0);
    @(negedge clk);
    chk("t1_show", show_face, 1);
    chk("t1_id", active_id, 1);
    chk("t1_eyes", eyes, 7'h22);
    chk("t1_mouth", mouth, 7'h15);
    ticks(2);
    chk("t1_still_on", show_face, 1);
    tick1();
    chk("t1_off", show_face, 0);
    chk("t1_blank", eyes, 7'h7F);
    pulse(4'b0100);
    chk("t1_gap_queue", pending, 4'b0100);
    tick1();
    chk("t1_gap1_blank", show_face, 0);
    tick1();
    chk("t1_after_gap", show_face, 1);
    chk("t1_after_gap_id", active_id, 2);
    ticks(3 + GAP);

    // 2: simultaneous pulses served in priority order
    pulse(4'b1001);
    chk("t2_pend", pending, 4'b1001);
    @(negedge clk);
    chk("t2_id0", active_id, 0);
    chk("t2_pend_rest", pending, 4'b1000);
    chk("t2_eyes0", eyes, 7'h11);
    ticks(3 + GAP);
    chk("t2_id3", active_id, 3);
    chk("t2_show3", show_face, 1);
    chk("t2_pend0", pending, 0);
    chk("t2_mouth3", mouth, 7'h35);
    ticks(3 + GAP);

    // 3: retrigger, alone and together with a tick; pattern changes must not leak
    hold_ticks = 16'd5;
    pulse(4'b0100);
    @(negedge clk);
    eyes_pat[20:14] = 7'h55;
    ticks(3);
    chk("t3_latched", eyes, 7'h33);
    pulse(4'b0100);
    count_show(n);
    chk("t3_retrig_ticks", n, 5);
    ticks(GAP);
    eyes_pat[20:14] = 7'h33;
    pulse(4'b0100);
    @(negedge clk);
    ticks(3);
    event_pulse = 4'b0100;
    tick = 1'b1;
    @(negedge clk);
    event_pulse = '0;
    tick = 1'b0;
    @(negedge clk);
    count_show(n);
    chk("t3_retrig_tick_ticks", n, 5);
    ticks(GAP);

    // 4: zero hold acts as one tick; repeated pulses on a queued channel collapse
    hold_ticks = 16'd0;
    pulse(4'b0001);
    @(negedge clk);
    pulse(4'b1000);
    pulse(4'b1000);
    pulse(4'b1000);
    chk("t4_pend_once", pending, 4'b1000);
    tick1();
    chk("t4_one_tick", show_face, 0);
    ticks(GAP);
    chk("t4_ch3", active_id, 3);
    tick1();
    chk("t4_ch3_off", show_face, 0);
    ticks(GAP);
    repeat (4) @(negedge clk);
    chk("t4_no_second", show_face, 0);
    chk("t4_pend_empty", pending, 0);

    // 5: asynchronous reset mid-show
    hold_ticks = 16'd3;
    pulse(4'b0010);
    @(negedge clk);
    pulse(4'b0100);
    #2 rst = 1'b1;
    #1;
    chk("t5_show", show_face, 0);
    chk("t5_eyes", eyes, 7'h7F);
    chk("t5_mouth", mouth, 7'h7F);
    chk("t5_pending", pending, 0);
    chk("t5_active", active_id, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 6: higher-priority event during a show
    pulse(4'b0100);
    @(negedge clk);
    pulse(4'b0001);
    chk("t6_pend", pending, 4'b0001);
    @(negedge clk);
`ifdef FACE_PREEMPT_EN
    chk("t6_preempt_id", active_id, 0);
    chk("t6_preempt_show", show_face, 1);
    chk("t6_preempt_pend", pending, 0);
    ticks(3 + GAP);
`else
    chk("t6_wait_id", active_id, 2);
    chk("t6_wait_pend", pending, 4'b0001);
    ticks(3);
    chk("t6_ch2_off", show_face, 0);
    ticks(GAP);
    chk("t6_ch0_id", active_id, 0);
    chk("t6_ch0_show", show_face, 1);
    ticks(3 + GAP);
`endif
    repeat (3) @(negedge clk);
    chk("end_idle", show_face, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
